// File: rtl/dmem_responder.sv
// dmem_responder: single-port 32-bit data memory answering one core request at a time.
// Latency: request accepted on edge T, rsp_valid first high LATENCY+1 cycles after the request cycle.
// Backpressure: one outstanding access; req_ready low outside IDLE, response held until rsp_ready.
//
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   req_valid/req_ready             - request handshake
//   req_addr, req_wmask, req_wdata  - byte address, lane write enables (0 = read), store data
//   rsp_valid/rsp_ready             - response handshake
//   rsp_rdata, rsp_err              - load data, access rejected
//   busy                            - FSM not in IDLE
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject accesses with req_addr[1:0] != 0.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_wmask,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        access;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wmask_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] mem [DEPTH_WORDS];

   // With LATENCY=0 the access happens on the accept edge itself, so the
   // live request fields are used in IDLE and the captured copy elsewhere.
   logic [31:0]      cur_addr, cur_wdata;
   logic [3:0]       cur_wmask;
   logic [IDX_W-1:0] idx;
   logic             out_of_range, misalign, reject, is_write, do_write;

   assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign cur_wmask = (state == IDLE) ? req_wmask : wmask_q;

   assign idx          = cur_addr[IDX_W+1:2];
   assign out_of_range = |cur_addr[31:IDX_W+2];
   assign is_write     = |cur_wmask;

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign = |cur_addr[1:0];
`else
   logic unused_low_bits;
   assign unused_low_bits = ^cur_addr[1:0];
   assign misalign        = 1'b0;
`endif

   assign reject = out_of_range | misalign;
   // Gate with reset so an access can never land while reset is held.
   assign do_write = access & ~reset & is_write & ~reject;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      access    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cnt_nxt = 4'(LATENCY);
               if (LATENCY == 0) begin
                  state_nxt = RESP;
                  access    = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            // Counter reaches zero on this edge: enter RESP and access memory.
            if (cnt <= 4'd1) begin
               cnt_nxt   = 4'd0;
               state_nxt = RESP;
               access    = 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wmask_q <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
         end
         if (access) begin
            rdata_q <= (reject || is_write) ? 32'd0 : mem[idx];
            err_q   <= reject;
         end else if (state == RESP && rsp_ready) begin
            // Response data is zero whenever rsp_valid is low.
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
         end
      end
   end

   // Storage has no reset: contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_wmask[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
         end
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign busy      = (state != IDLE);

endmodule
